// File: rtl/systolic_ctrl.sv
// Loads A/B into local buffers, clears the MAC array, streams skewed operands, then drains results row-major.
// Latency DIM*DIM clear + 3*DIM-1 feed cycles before the first result; the drain stalls on res_ready.
module systolic_ctrl #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_en,
  input  logic                     ld_sel,
  input  logic [$clog2(DIM)-1:0]   ld_idx,
  input  logic [DIM*BITS_AB-1:0]   ld_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     arr_en,
  output logic                     arr_WrEn,
  output logic [BITS_C-1:0]        arr_Cin,
  output logic [$clog2(DIM)-1:0]   arr_row,
  output logic [$clog2(DIM)-1:0]   arr_col,
  output logic [DIM*BITS_AB-1:0]   arr_A,
  output logic [DIM*BITS_AB-1:0]   arr_B,
  input  logic [BITS_C-1:0]        arr_Cout,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [BITS_C-1:0]        res_data,
  output logic                     res_last
);

  localparam int LW = $clog2(DIM);
  localparam int CW = 2 * LW;
  localparam int TW = $clog2(3 * DIM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic signed [BITS_AB-1:0] abuf [DIM][DIM];
  logic signed [BITS_AB-1:0] bbuf [DIM][DIM];

  logic hs, cell_last, feed_last;

  assign hs        = res_valid & res_ready;
  assign cell_last = &cnt;
  assign feed_last = (tcnt == TW'(3 * DIM - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    arr_en    = 1'b0;
    arr_WrEn  = 1'b0;
    arr_Cin   = '0;
    arr_row   = '0;
    arr_col   = '0;
    res_valid = 1'b0;
    res_data  = '0;
    res_last  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        busy     = 1'b1;
        arr_WrEn = 1'b1;
        arr_row  = cnt[CW-1:LW];
        arr_col  = cnt[LW-1:0];
        if (cell_last) state_nxt = S_FEED;
      end
      S_FEED: begin
        busy   = 1'b1;
        arr_en = 1'b1;
        if (feed_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        arr_row   = cnt[CW-1:LW];
        arr_col   = cnt[LW-1:0];
        res_valid = 1'b1;
        res_data  = arr_Cout;
        res_last  = cell_last;
        if (hs && cell_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // cnt is exactly 2*log2(DIM) wide, so it wraps back to 0 after the last cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tcnt <= '0;
    end else begin
      case (state)
        S_CLEAR: cnt  <= cnt + 1'b1;
        S_FEED:  tcnt <= tcnt + 1'b1;
        S_DRAIN: if (hs) cnt <= cnt + 1'b1;
        default: begin
          cnt  <= '0;
          tcnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          abuf[i][j] <= '0;
          bbuf[i][j] <= '0;
        end
      end
    end else if (ld_en && !busy) begin
      for (int k = 0; k < DIM; k++) begin
        if (!ld_sel) abuf[ld_idx][k] <= ld_data[k*BITS_AB +: BITS_AB];
        else         bbuf[k][ld_idx] <= ld_data[k*BITS_AB +: BITS_AB];
      end
    end
  end

  // Diagonal skew: lane i carries element (t - i) of its row/column, zero outside the window.
  always_comb begin
    arr_A = '0;
    arr_B = '0;
    if (state == S_FEED) begin
      for (int i = 0; i < DIM; i++) begin
        if (int'(tcnt) >= i && int'(tcnt) < i + DIM) begin
          arr_A[i*BITS_AB +: BITS_AB] = abuf[i][LW'(int'(tcnt) - i)];
          arr_B[i*BITS_AB +: BITS_AB] = bbuf[LW'(int'(tcnt) - i)][i];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: a cycle-level systolic array model feeds arr_Cout; expected results come from plain matrix products.
module tb_systolic_ctrl;
  localparam int DIM = 8;
  localparam int BAB = 8;
  localparam int BC  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             ld_en, ld_sel, start, res_ready;
  logic [2:0]       ld_idx;
  logic [63:0]      ld_data;
  logic             busy, done, arr_en, arr_WrEn, res_valid, res_last;
  logic [BC-1:0]    arr_Cin, arr_Cout, res_data;
  logic [2:0]       arr_row, arr_col;
  logic [63:0]      arr_A, arr_B;

  systolic_ctrl #(.BITS_AB(BAB), .BITS_C(BC), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_idx(ld_idx), .ld_data(ld_data),
    .start(start), .busy(busy), .done(done), .arr_en(arr_en), .arr_WrEn(arr_WrEn),
    .arr_Cin(arr_Cin), .arr_row(arr_row), .arr_col(arr_col), .arr_A(arr_A), .arr_B(arr_B),
    .arr_Cout(arr_Cout), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last)
  );

  always #5 clk = ~clk;

  // Output-stationary array: A moves right, B moves down, each cell accumulates a*b.
  logic signed [BAB-1:0] ar [DIM][DIM];
  logic signed [BAB-1:0] br [DIM][DIM];
  logic signed [BC-1:0]  acc [DIM][DIM];
  assign arr_Cout = acc[arr_row][arr_col];

  always @(posedge clk) begin
    logic signed [BAB-1:0] ain, bin;
    logic signed [BC-1:0]  p;
    if (arr_WrEn) begin
      acc[arr_row][arr_col] <= arr_Cin;
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          ar[i][j] <= '0;
          br[i][j] <= '0;
        end
    end else if (arr_en) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          if (j == 0) ain = arr_A[i*BAB +: BAB]; else ain = ar[i][j-1];
          if (i == 0) bin = arr_B[j*BAB +: BAB]; else bin = br[i-1][j];
          p = ain * bin;
          ar[i][j]  <= ain;
          br[i][j]  <= bin;
          acc[i][j] <= acc[i][j] + p;
        end
    end
  end

  typedef struct {
    logic [BC-1:0] d;
    bit            last;
  } exp_t;
  exp_t exp_q[$];

  logic signed [BAB-1:0] ma [DIM][DIM];
  logic signed [BAB-1:0] mb [DIM][DIM];

  int cmp_n = 0, err_n = 0;
  int cyc = 0;
  int wr_cnt, hs_cnt = 0, done_cnt = 0, last_hs_cyc = -10, done_cyc = 0, first_valid_cyc = 0;
  bit seen_valid, hold_pend = 0;
  logic [BC-1:0] held_data;
  int rmode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       res_ready = 1'b1;
      1:       res_ready = ~res_ready;
      default: res_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (arr_WrEn) wr_cnt++;
      if (res_valid && !seen_valid) begin
        seen_valid      = 1'b1;
        first_valid_cyc = cyc;
      end
      if (hold_pend) begin
        check("hold_valid", {63'd0, res_valid}, 64'd1);
        check("hold_data", {48'd0, res_data}, {48'd0, held_data});
        hold_pend = 1'b0;
      end
      if (res_valid) begin
        if (res_ready) begin
          if (exp_q.size() == 0) begin
            cmp_n++;
            err_n++;
            $display("FAIL extra_result: got %0h expected none", res_data);
          end else begin
            e = exp_q.pop_front();
            check("res_data", {48'd0, res_data}, {48'd0, e.d});
            check("res_last", {63'd0, res_last}, {63'd0, e.last});
          end
          hs_cnt++;
          last_hs_cyc = cyc;
        end else begin
          held_data = res_data;
          hold_pend = 1'b1;
        end
      end
      if (done) begin
        check("done_after_last", 64'(cyc), 64'(last_hs_cyc + 1));
        check("done_busy", {63'd0, busy}, 64'd0);
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load();
    ld_en = 1'b1;
    for (int r = 0; r < DIM; r++) begin
      ld_sel = 1'b0;
      ld_idx = 3'(r);
      for (int k = 0; k < DIM; k++) ld_data[k*BAB +: BAB] = ma[r][k];
      tick();
    end
    for (int c = 0; c < DIM; c++) begin
      ld_sel = 1'b1;
      ld_idx = 3'(c);
      for (int k = 0; k < DIM; k++) ld_data[k*BAB +: BAB] = mb[k][c];
      tick();
    end
    ld_en = 1'b0;
  endtask

  task automatic push_expected();
    exp_t e;
    int   sum;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        sum = 0;
        for (int k = 0; k < DIM; k++) sum += int'(ma[i][k]) * int'(mb[k][j]);
        e.d    = sum[BC-1:0];
        e.last = (i == DIM - 1) && (j == DIM - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic run(input string tag, input bit chk_lat, input bit disturb);
    int s, d0, h0, n;
    push_expected();
    wr_cnt     = 0;
    seen_valid = 1'b0;
    d0         = done_cnt;
    h0         = hs_cnt;
    start      = 1'b1;
    s          = cyc;
    tick();
    start = 1'b0;
    if (disturb) begin
      repeat (69) tick();
      start   = 1'b1;
      ld_en   = 1'b1;
      ld_sel  = 1'b0;
      ld_idx  = 3'd3;
      ld_data = {$urandom, $urandom};
      tick();
      start = 1'b0;
      ld_en = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 64'(done_cnt), 64'(d0 + 1));
    check({tag, "_count"}, 64'(hs_cnt - h0), 64'd64);
    check({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_clear_cycles"}, 64'(wr_cnt), 64'd64);
    if (chk_lat) begin
      check({tag, "_first_valid"}, 64'(first_valid_cyc - s), 64'd88);
      check({tag, "_done_cycle"}, 64'(done_cyc - s), 64'd152);
    end
    exp_q.delete();
    tick();
  endtask

  task automatic fill(input int mode, input int va, input int vb);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        case (mode)
          0: begin ma[i][j] = (i == j) ? 8'sd1 : 8'sd0; mb[i][j] = 8'(i * 8 + j); end
          1: begin ma[i][j] = 8'(va); mb[i][j] = 8'(vb); end
          2: begin ma[i][j] = 8'($urandom); mb[i][j] = 8'($urandom); end
          default: begin ma[i][j] = '0; mb[i][j] = '0; end
        endcase
      end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_sel = 1'b0; ld_idx = '0; ld_data = '0; start = 1'b0; res_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_wren", {63'd0, arr_WrEn}, 64'd0);
    check("rst_en", {63'd0, arr_en}, 64'd0);
    check("rst_arr_A", arr_A, 64'd0);
    check("rst_arr_B", arr_B, 64'd0);
    tick();

    rmode = 0;
    fill(0, 0, 0); load(); run("ident", 1'b1, 1'b0);
    fill(1, 1, 1); load(); run("ones", 1'b1, 1'b0);
    run("ones_rerun", 1'b1, 1'b0);
    fill(1, -128, -128); load(); run("wrap", 1'b0, 1'b0);
    fill(1, -1, 2); load(); run("neg", 1'b0, 1'b0);

    rmode = 1;
    fill(2, 0, 0); load(); run("toggle", 1'b0, 1'b0);

    rmode = 0;
    fill(2, 0, 0); load(); run("disturb", 1'b0, 1'b1);

    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (74) tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_en", {63'd0, arr_en}, 64'd0);
    check("midrst_valid", {63'd0, res_valid}, 64'd0);
    tick();
    rst = 1'b0;
    hold_pend = 1'b0;
    tick();
    fill(3, 0, 0); run("cleared_bufs", 1'b1, 1'b0);
    fill(2, 0, 0); load(); run("after_rst", 1'b1, 1'b0);

    rmode = 2;
    for (int r = 0; r < 4; r++) begin
      fill(2, 0, 0);
      load();
      run("random", 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Sequencer for the DIM x DIM output-stationary signed MAC array used by the MatMul engine. It holds one A matrix and one B matrix in local buffers and clears the array accumulators. It then streams A and B into the array edges with diagonal skew. Finally it drains all DIM*DIM results in row-major order over a valid/ready output port.

Parameters:
BITS_AB, 8, signed operand width of A and B elements
BITS_C, 16, signed accumulator/result width
DIM, 8, array dimension (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
ld_en  in  1  buffer write strobe; honoured only when busy=0
ld_sel  in  1  0 = A buffer (ld_idx = row), 1 = B buffer (ld_idx = column)
ld_idx  in  $clog2(DIM)  row of A / column of B being written
ld_data  in  DIM*BITS_AB  element k at bits [k*BITS_AB +: BITS_AB]; A[ld_idx][k] or B[k][ld_idx]
start  in  1  begin a multiply; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last result handshake
arr_en  out  1  array enable
arr_WrEn  out  1  array accumulator write
arr_Cin  out  BITS_C  array write data (always 0)
arr_row  out  $clog2(DIM)  array cell select, row
arr_col  out  $clog2(DIM)  array cell select, column
arr_A  out  DIM*BITS_AB  row-edge operands, lane i = array row i
arr_B  out  DIM*BITS_AB  column-edge operands, lane j = array column j
arr_Cout  in  BITS_C  selected cell result (combinational from arr_row/arr_col)
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  BITS_C  equals arr_Cout while res_valid
res_last  out  1  high with the final result (row DIM-1, col DIM-1)

Behaviour:
- Reset (async, any state): state=IDLE; counters and both buffers cleared to 0; all outputs 0.
- IDLE
  - ld_en writes one row of A or one column of B per cycle.
  - start=1 -> CLEAR on the next edge; busy rises on that edge.
  - ld_en and start in the same cycle: the write completes, then CLEAR.
- CLEAR: DIM*DIM cycles.
  - arr_WrEn=1, arr_Cin=0, arr_en=0.
  - {arr_row,arr_col} step row-major from (0,0) to (DIM-1,DIM-1), one cell per cycle.
  - After the last cell -> FEED.
- FEED: feed counter t = 0 .. 3*DIM-2 (3*DIM-1 cycles); arr_en=1, arr_WrEn=0.
  - Lane i of arr_A = A[i][t-i] when 0<=t-i<DIM, else 0.
  - Lane j of arr_B = B[t-j][j] when 0<=t-j<DIM, else 0.
  - The final cycle carries all-zero lanes so the last products settle.
  - Outside FEED, arr_A, arr_B and arr_en are 0.
- DRAIN: arr_en=0; arr_row/arr_col index the current result; res_valid=1; res_data=arr_Cout.
  - On res_valid & res_ready, advance row-major; hold otherwise (data stable under backpressure).
  - Handshake with res_last -> DONE.
- DONE: done=1 for one cycle, busy=0 in this cycle, then IDLE.
- start outside IDLE is ignored; ld_en while busy=1 is ignored (buffers unchanged).
- Buffers persist across operations, so the same A/B can be re-run with another start.
- Arithmetic: result = sum over k of A[i][k]*B[k][j], signed, wrapping modulo 2^BITS_C (array behaviour; no saturation in this block).
- Latency (DIM=8), counting the start cycle as cycle 0:
  - CLEAR occupies cycles 1..64.
  - FEED occupies cycles 65..87.
  - First res_valid in cycle 88.
  - With res_ready held high, the last handshake is in cycle 151 and done is in cycle 152.
- rst mid-operation: state returns to IDLE immediately and buffers are cleared. Array accumulator contents are undefined until the next CLEAR.

Test Plan:
- Reset, then check outputs: busy=0, done=0, res_valid=0, arr_WrEn=0, arr_en=0, arr_A=0, arr_B=0.
- A=identity, B[k][j]=k*8+j, start, res_ready=1 -> 64 results equal to 0..63 in order; res_last on the 64th; done in cycle 152; arr_WrEn high for exactly 64 cycles.
- A and B all 1 -> every result = 8. Re-run start without reloading -> 8 again (proves CLEAR resets the accumulators).
- A and B all -128 -> each sum 131072 wraps to 0. A all -1, B all 2 -> every result -16.
- Toggle res_ready 1/0 every cycle -> res_data/res_valid held while ready=0; 64 results, no loss or duplication; done one cycle after the last handshake.
- start and ld_en pulsed during FEED -> ignored, results unchanged. rst pulsed mid-FEED -> IDLE next sample, busy=0; then reload, start, and the correct results follow.
